// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipe_stage_reg boundary: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 288,
  parameter int CTRL_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (output in_valid, in_data, in_ctrl, out_ready,
                  input  in_ready, out_valid, out_data, out_ctrl);
  modport slave  (input  in_valid, in_data, in_ctrl, out_ready,
                  output in_ready, out_valid, out_data, out_ctrl);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready flow, flush-to-bubble, optional skid entry,
// and saturating stall/flush counters for the performance monitor.
module pipe_stage_reg #(
  parameter int DATA_W = 288,
  parameter int CTRL_W = 9,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             clr_cnt,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, in_e;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             out_valid, in_ready, in_hs, out_hs;

  assign in_e      = {bus.in_data, bus.in_ctrl};
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = SKID ? in_ready_q : ((!out_valid || bus.out_ready) && !flush);
  // A flush drops any offered entry even when the registered ready is high.
  assign in_hs     = bus.in_valid && in_ready && !flush;
  assign out_hs    = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_hs) begin
          main_d  = in_e;
          state_d = ONE;
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_d = in_e;
          end else if (in_hs) begin
            skid_d  = in_e;
            state_d = TWO;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_hs) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO) && !flush;
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (out_valid && !bus.out_ready && !flush && stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
      if (flush && out_valid && flush_q != CNT_MAX)                    flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q.data;
  assign bus.out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;
  assign occupancy     = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one SKID=0 and one SKID=1 stage with shared stimulus; each has its own FIFO-model scoreboard.
module tb_pipe_stage_reg;
  localparam int DW = 32, CW = 9, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b0;
  logic flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) if0 (), if1 ();

  logic          ov  [2];
  logic          ir  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [CNT_W-1:0] sc [2];
  logic [CNT_W-1:0] fc [2];
  logic [1:0]    occ [2];

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_data  = in_data;   assign if1.in_data  = in_data;
  assign if0.in_ctrl  = in_ctrl;   assign if1.in_ctrl  = in_ctrl;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid;
  assign ir[0] = if0.in_ready;  assign ir[1] = if1.in_ready;
  assign od[0] = if0.out_data;  assign od[1] = if1.out_data;
  assign oc[0] = if0.out_ctrl;  assign oc[1] = if1.out_ctrl;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt), .bus(if0),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]), .occupancy(occ[0]));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt), .bus(if1),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]), .occupancy(occ[1]));

  task automatic check(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  for (genvar g = 0; g < 2; g++) begin : sb
    localparam bit SK = (g == 1);
    ent_t q[$];
    int   n_neg   = 0;
    bit   rdy_now = 1'b0;
    bit   rdy_reg = 1'b0;
    int   st_m = 0, fl_m = 0;

    // Monitor: compares what the stage presents against the head of the expected FIFO.
    initial forever begin
      int n;
      bit pr;
      @(negedge clk);
      n  = q.size();
      pr = SK ? rdy_reg : ((n == 0 || out_ready) && !flush);
      check("out_valid", g, 64'(ov[g]), 64'(n != 0));
      check("occupancy", g, 64'(occ[g]), 64'(n));
      if (n != 0) begin
        check("out_data", g, 64'(od[g]), 64'(q[0].d));
        check("out_ctrl", g, 64'(oc[g]), 64'(q[0].c));
      end else begin
        check("bubble_ctrl", g, 64'(oc[g]), 64'(0));
      end
      check("in_ready", g, 64'(ir[g]), 64'(pr));
      check("stall_cnt", g, 64'(sc[g]), 64'(st_m));
      check("flush_cnt", g, 64'(fc[g]), 64'(fl_m));
      rdy_now = pr;
      n_neg   = n;
      if (n != 0 && out_ready) void'(q.pop_front());
    end

    // Reference model: a FIFO of capacity 2 (skid) or 1, plus saturating counters.
    initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        st_m = 0; fl_m = 0; rdy_reg = 1'b0;
      end else begin
        if (flush) q.delete();
        else if (in_valid && rdy_now) q.push_back(ent_t'({in_data, in_ctrl}));
        if (clr_cnt) begin
          st_m = 0; fl_m = 0;
        end else begin
          if (n_neg != 0 && !out_ready && !flush && st_m < CMAX) st_m++;
          if (flush && n_neg != 0 && fl_m < CMAX) fl_m++;
        end
        rdy_reg = (q.size() < 2) && !flush;
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r,
                       input bit f = 1'b0, input bit c = 1'b0);
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = CW'($urandom);
    out_ready = r;
    flush     = f;
    clr_cnt   = c;
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 2; g++) begin
      check("rst_out_valid", g, 64'(ov[g]), 64'(0));
      check("rst_out_ctrl",  g, 64'(oc[g]), 64'(0));
      check("rst_out_data",  g, 64'(od[g]), 64'(0));
      check("rst_occupancy", g, 64'(occ[g]), 64'(0));
      check("rst_stall_cnt", g, 64'(sc[g]), 64'(0));
      check("rst_flush_cnt", g, 64'(fc[g]), 64'(0));
    end
    check("rst_in_ready", 0, 64'(ir[0]), 64'(1));
    check("rst_in_ready", 1, 64'(ir[1]), 64'(0));
  endtask

  initial begin
    repeat (3) drive(1'b0, '0, 1'b0);
    check_reset_outputs();
    @(posedge clk); #1 reset = 1'b1;

    // Straight stream 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1);

    // Three cycles of backpressure while upstream keeps offering
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(16 + i), 1'b0);
    for (int i = 3; i < 6; i++) drive(1'b1, DW'(16 + i), 1'b1);
    repeat (4) drive(1'b0, '0, 1'b1);

    // Fill to TWO, then flush with 0xAA on the input; then a flush while empty
    drive(1'b1, DW'('h30), 1'b0);
    drive(1'b1, DW'('h31), 1'b0);
    drive(1'b1, DW'('hAA), 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);

    // Long stall saturates stall_cnt; clear wins over a still-present stall
    drive(1'b1, DW'('h40), 1'b0);
    repeat (20) drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1);

    // Randomized traffic with occasional flush and counter clear
    repeat (1500)
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    repeat (3) drive(1'b0, '0, 1'b1);

    // Asynchronous reset in the middle of a cycle while the skid stage holds two entries
    drive(1'b1, DW'('h50), 1'b0);
    drive(1'b1, DW'('h51), 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; in_data = DW'('h55); out_ready = 1'b1;
    drive(1'b1, DW'('h56), 1'b1);
    repeat (4) drive(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
